// File: rtl/uart_mem_pkg.sv
// Shared constants and state encoding for the UART memory loader.
package uart_mem_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_HI  = 3'd1,
        ADDR_LO  = 3'd2,
        DATA     = 3'd3,
        RD_ISSUE = 3'd4,
        RD_CAPT  = 3'd5,
        TX       = 3'd6
    } state_t;

    // True for the two command bytes the loader understands.
    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_mem_loader.sv
// UART byte-stream to memory bridge.
// 'W' AH AL D writes D to {AH,AL}; 'R' AH AL reads {AH,AL} and returns the byte.
// Writes answer 'K', unknown command bytes answer '?'. An inter-byte timeout
// abandons a partial command without touching memory.
//
// tx handshake: tx_we is a request that stays high with tx_data stable until a
// cycle where tx_wait=0; that cycle is the hand-over and the next cycle has
// tx_we=0. rx has no back-pressure: a byte arriving while a read or a response
// is in flight is dropped and recorded in the sticky overrun flag.
module uart_mem_loader
    import uart_mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_we,
    input  logic              tx_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              overrun,
    output state_t            dbg_state
);

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [7:0]          addr_hi_q, addr_hi_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          tx_data_d;
    logic                tx_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [7:0]          mem_wdata_d;
    logic                mem_we_d;
    logic                mem_re_d;
    logic                overrun_d;
    logic                counting;
    logic                timed_out;

    assign dbg_state = state_q;

    // Next-state, registered-output and timeout-counter logic.
    always_comb begin
        state_d     = state_q;
        cmd_wr_d    = cmd_wr_q;
        addr_hi_d   = addr_hi_q;
        tx_data_d   = tx_data;
        tx_we_d     = tx_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        overrun_d   = overrun;

        counting  = (state_q == ADDR_HI) || (state_q == ADDR_LO) || (state_q == DATA);
        // A byte arriving on the timeout cycle wins over the timeout.
        timed_out = counting && (cnt_q == CNT_MAX) && !rx_valid;

        // Counter saturates rather than wrapping; cleared by any accepted byte.
        if (!counting || rx_valid) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (is_cmd(rx_data)) begin
                        cmd_wr_d = (rx_data == CMD_WR);
                        state_d  = ADDR_HI;
                    end else begin
                        tx_data_d = RSP_ERR;
                        tx_we_d   = 1'b1;
                        state_d   = TX;
                    end
                end
            end
            ADDR_HI: begin
                if (rx_valid) begin
                    addr_hi_d = rx_data;
                    state_d   = ADDR_LO;
                end else if (timed_out) begin
                    state_d = IDLE;
                end
            end
            ADDR_LO: begin
                if (rx_valid) begin
                    mem_addr_d = ADDR_W'({addr_hi_q, rx_data});
                    if (cmd_wr_q) begin
                        state_d = DATA;
                    end else begin
                        mem_re_d = 1'b1;
                        state_d  = RD_ISSUE;
                    end
                end else if (timed_out) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    mem_wdata_d = rx_data;
                    mem_we_d    = 1'b1;
                    tx_data_d   = RSP_OK;
                    tx_we_d     = 1'b1;
                    state_d     = TX;
                end else if (timed_out) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAPT;
            end
            RD_CAPT: begin
                // Read data is valid now, one cycle after the strobe.
                tx_data_d = mem_rdata;
                tx_we_d   = 1'b1;
                state_d   = TX;
            end
            TX: begin
                if (!tx_wait) begin
                    tx_we_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_valid && ((state_q == RD_ISSUE) || (state_q == RD_CAPT) || (state_q == TX))) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cmd_wr_q  <= 1'b0;
            addr_hi_q <= '0;
            cnt_q     <= '0;
            tx_data   <= '0;
            tx_we     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_wr_q  <= cmd_wr_d;
            addr_hi_q <= addr_hi_d;
            cnt_q     <= cnt_d;
            tx_data   <= tx_data_d;
            tx_we     <= tx_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_we    <= mem_we_d;
            mem_re    <= mem_re_d;
            overrun   <= overrun_d;
        end
    end

endmodule
